// File: rtl/packet_buffer_streamer_pkg.sv
// Shared constants, clog2 helper and FSM state encoding for the packet buffer streamer.
// Default buffer geometry lives here so the RAM driver and the streamer agree on it.
package packet_buffer_streamer_pkg;

  localparam int BYTE_LEN                   = 8;
  localparam int PACKET_BUFFER_SIZE         = 64;
  localparam int PACKET_BUFFER_READ_LATENCY = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } stream_state_e;

endpackage

// File: rtl/packet_buffer_streamer_if.sv
// RAM read port plus outgoing byte stream of the streamer.
// master = streamer side, slave = RAM driver / downstream side.
interface packet_buffer_streamer_if
  import packet_buffer_streamer_pkg::*;
#(
  parameter int AW     = clog2(PACKET_BUFFER_SIZE),
  parameter int BYTE_W = BYTE_LEN
);

  logic              read_req;
  logic [AW-1:0]     read_addr;
  logic              read_ready;
  logic [BYTE_W-1:0] read_in;

  logic              out_valid;
  logic              out_ready;
  logic [BYTE_W-1:0] out_data;
  logic              out_last;

  modport master (
    output read_req, read_addr,
    input  read_ready, read_in,
    output out_valid, out_data, out_last,
    input  out_ready
  );

  modport slave (
    input  read_req, read_addr,
    output read_ready, read_in,
    input  out_valid, out_data, out_last,
    output out_ready
  );

endinterface

// File: rtl/packet_buffer_streamer_fifo.sv
// byte_stream_fifo: synchronous first-word fall-through FIFO with occupancy count.
// Depth need not be a power of two; the head reads as zero while empty.
module byte_stream_fifo
  import packet_buffer_streamer_pkg::*;
#(
  parameter int W     = BYTE_LEN + 1,
  parameter int DEPTH = PACKET_BUFFER_READ_LATENCY + 2,
  parameter int CW    = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [W-1:0]  wr_data,
  input  logic          rd_en,
  output logic [W-1:0]  rd_data,
  output logic          valid,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_wr;
  logic          do_rd;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign valid   = (count != '0);
  assign do_rd   = rd_en && valid;
  assign do_wr   = wr_en && (count != CW'(DEPTH));
  assign rd_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

endmodule

// File: rtl/packet_buffer_streamer.sv
// Read-side sequencer: fetches `length` bytes from the packet buffer RAM and streams them out.
// Optional feature: define PACKET_STREAMER_ABORT_EN to add the `abort` input.
module packet_buffer_streamer
  import packet_buffer_streamer_pkg::*;
#(
  parameter int  RAM_SIZE     = PACKET_BUFFER_SIZE,
  parameter int  READ_LATENCY = PACKET_BUFFER_READ_LATENCY,
  parameter int  FIFO_DEPTH   = READ_LATENCY + 2,
  localparam int AW           = clog2(RAM_SIZE)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] start_addr,
  input  logic [AW:0]   length,
  output logic          busy,
  output logic          done,
`ifdef PACKET_STREAMER_ABORT_EN
  input  logic          abort,
`endif
  packet_buffer_streamer_if.master bus
);

  localparam int          CW      = clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  stream_state_e     state_q;
  stream_state_e     state_d;
  logic [AW-1:0]     addr_q;
  logic [AW:0]       req_left_q;
  logic [AW:0]       wr_left_q;
  logic [CW-1:0]     inflight_q;
  logic [CW-1:0]     fifo_count;
  logic [BYTE_LEN:0] fifo_head;
  logic              fifo_valid;
  logic              done_q;
  logic              start_ok;
  logic              can_issue;
  logic              ret_ok;
  logic              wr_en;
  logic              pop;
  logic              final_hs;
  logic              abort_now;
  logic              aborting;

`ifdef PACKET_STREAMER_ABORT_EN
  logic aborting_q;
  assign abort_now = abort && (state_q != ST_IDLE) && !aborting_q;
  assign aborting  = aborting_q || abort_now;
`else
  assign abort_now = 1'b0;
  assign aborting  = 1'b0;
`endif

  assign start_ok  = start && (state_q == ST_IDLE);
  // Requests in flight plus bytes held never exceed the FIFO, so a return always has a slot.
  assign can_issue = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_C;

  assign bus.read_req  = (state_q == ST_FETCH) && !aborting && can_issue;
  assign bus.read_addr = addr_q;

  // Returns with nothing outstanding (stale after reset, or while idle) are dropped.
  assign ret_ok   = bus.read_ready && (state_q != ST_IDLE) && (inflight_q != '0);
  assign wr_en    = ret_ok && !aborting;
  assign pop      = bus.out_valid && bus.out_ready;
  assign final_hs = pop && bus.out_last;

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok && (length != '0)) state_d = ST_FETCH;
      ST_FETCH: if (bus.read_req && (req_left_q == (AW + 1)'(1))) state_d = ST_DRAIN;
      ST_DRAIN: if (final_hs) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
`ifdef PACKET_STREAMER_ABORT_EN
    if (aborting_q && (inflight_q == '0)) state_d = ST_IDLE;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      req_left_q <= '0;
      wr_left_q  <= '0;
      inflight_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_q + CW'(bus.read_req) - CW'(ret_ok);
      done_q     <= (start_ok && (length == '0)) || (final_hs && !aborting);
      if (start_ok) begin
        addr_q     <= start_addr;
        req_left_q <= length;
        wr_left_q  <= length;
      end else begin
        if (bus.read_req) begin
          addr_q     <= (addr_q == AW'(RAM_SIZE - 1)) ? '0 : addr_q + AW'(1);
          req_left_q <= req_left_q - (AW + 1)'(1);
        end
        if (wr_en) wr_left_q <= wr_left_q - (AW + 1)'(1);
      end
    end
  end

`ifdef PACKET_STREAMER_ABORT_EN
  always_ff @(posedge clk) begin
    if (!reset) aborting_q <= 1'b0;
    else        aborting_q <= aborting && (state_d != ST_IDLE);
  end
`endif

  // Return stage -> output FIFO; the byte tagged last is the length-th one written.
  byte_stream_fifo #(
    .W     (BYTE_LEN + 1),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (abort_now),
    .wr_en   (wr_en),
    .wr_data ({(wr_left_q == (AW + 1)'(1)), bus.read_in}),
    .rd_en   (pop),
    .rd_data (fifo_head),
    .valid   (fifo_valid),
    .count   (fifo_count)
  );

  assign bus.out_valid = fifo_valid;
  assign bus.out_data  = fifo_head[BYTE_LEN-1:0];
  assign bus.out_last  = fifo_head[BYTE_LEN];

endmodule

// File: tb/tb_packet_buffer_streamer.sv
// Directed bench for packet_buffer_streamer with a fixed-latency RAM model on a
// non-power-of-two buffer.
module tb_packet_buffer_streamer;
  import packet_buffer_streamer_pkg::*;

  localparam int RAM_SIZE = 50;
  localparam int L        = 2;
  localparam int DEPTH    = L + 2;
  localparam int AW       = clog2(RAM_SIZE);

  logic          clk = 1'b0;
  logic          reset;
  logic          ram_rst_n;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
`ifdef PACKET_STREAMER_ABORT_EN
  logic          abort;
`endif

  packet_buffer_streamer_if #(.AW(AW), .BYTE_W(BYTE_LEN)) bus ();

  packet_buffer_streamer #(
    .RAM_SIZE     (RAM_SIZE),
    .READ_LATENCY (L),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .start_addr (start_addr),
    .length     (length),
    .busy       (busy),
    .done       (done),
`ifdef PACKET_STREAMER_ABORT_EN
    .abort      (abort),
`endif
    .bus        (bus)
  );

  always #5 clk = ~clk;

  // RAM model: fixed latency, not cleared by the DUT reset so stale returns occur.
  logic [BYTE_LEN-1:0] ram [RAM_SIZE];
  logic                rr_v [L];
  logic [AW-1:0]       rr_a [L];

  function automatic logic [BYTE_LEN-1:0] exp_byte(input int a);
    return BYTE_LEN'((a * 37 + 11) & 255);
  endfunction

  initial begin
    for (int i = 0; i < RAM_SIZE; i++) ram[i] = exp_byte(i);
  end

  always @(posedge clk) begin
    if (!ram_rst_n) begin
      for (int k = 0; k < L; k++) rr_v[k] <= 1'b0;
    end else begin
      rr_v[0] <= bus.read_req;
      rr_a[0] <= bus.read_addr;
      for (int k = 1; k < L; k++) begin
        rr_v[k] <= rr_v[k-1];
        rr_a[k] <= rr_a[k-1];
      end
    end
  end

  assign bus.read_ready = rr_v[L-1];
  assign bus.read_in    = rr_v[L-1] ? ram[rr_a[L-1]] : '0;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  int req_cyc[$];
  int req_addr[$];
  int hs_data[$];
  int hs_last[$];
  int hs_cyc[$];
  int first_val, last_val, nval, done_cyc, busy_max, busy_at_done, stall_err, occ_max;

  task automatic run_cmd(input int sa, input int len, input int pct, input int ign_cyc,
                         input int max_cyc);
    logic                pstall, pv, pl;
    logic [BYTE_LEN-1:0] pd;
    int                  c;
    req_cyc.delete(); req_addr.delete();
    hs_data.delete(); hs_last.delete(); hs_cyc.delete();
    first_val = -1; last_val = -1; nval = 0; done_cyc = -1; busy_max = 0;
    busy_at_done = -1; stall_err = 0; occ_max = 0;
    pstall = 1'b0; pv = 1'b0; pl = 1'b0; pd = '0;
    c = 0;
    @(negedge clk);
    start      = 1'b1;
    start_addr = AW'(sa);
    length     = (AW + 1)'(len);
    while (c <= max_cyc) begin
      if (c > 0) begin
        @(negedge clk);
        start = (c == ign_cyc);
        if (c == ign_cyc) begin
          start_addr = AW'(30);
          length     = (AW + 1)'(7);
        end
      end
      if (pstall && (bus.out_valid !== pv || bus.out_data !== pd || bus.out_last !== pl))
        stall_err++;
      if ((req_cyc.size() - hs_cyc.size()) > occ_max) occ_max = req_cyc.size() - hs_cyc.size();
      if (busy) busy_max = 1;
      if (bus.read_req) begin
        req_cyc.push_back(c);
        req_addr.push_back(int'(bus.read_addr));
      end
      if (bus.out_valid) begin
        nval++;
        if (first_val < 0) first_val = c;
        last_val = c;
      end
      bus.out_ready = ($urandom_range(99) < pct);
      if (bus.out_valid && bus.out_ready) begin
        hs_data.push_back(int'(bus.out_data));
        hs_last.push_back(int'(bus.out_last));
        hs_cyc.push_back(c);
      end
      pstall = bus.out_valid && !bus.out_ready;
      pv = bus.out_valid; pd = bus.out_data; pl = bus.out_last;
      if (done) begin
        done_cyc     = c;
        busy_at_done = int'(busy);
        break;
      end
      c++;
    end
    start = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_read_req"}, bus.read_req, 0);
    check({tag, "_read_addr"}, bus.read_addr, 0);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"}, bus.out_data, 0);
    check({tag, "_out_last"}, bus.out_last, 0);
  endtask

  task automatic check_stream(input string tag, input int sa, input int len);
    check({tag, "_nreq"}, req_cyc.size(), len);
    check({tag, "_nbytes"}, hs_data.size(), len);
    for (int i = 0; i < len && i < req_addr.size(); i++)
      check({tag, "_addr"}, req_addr[i], (sa + i) % RAM_SIZE);
    for (int i = 0; i < len && i < hs_data.size(); i++) begin
      check({tag, "_data"}, hs_data[i], exp_byte((sa + i) % RAM_SIZE));
      check({tag, "_last"}, hs_last[i], (i == len - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int cnt;
    int guard;
    int done_any;
    reset = 1'b0; ram_rst_n = 1'b0; start = 1'b0; start_addr = '0; length = '0;
    bus.out_ready = 1'b0;
`ifdef PACKET_STREAMER_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_outputs_zero("rst");
    reset = 1'b1; ram_rst_n = 1'b1;
    @(negedge clk);

    // Basic command: reads at 1..4, valid 4..7, last at 7, done at 8.
    run_cmd(10, 4, 100, -1, 40);
    check_stream("t1", 10, 4);
    for (int i = 0; i < 4 && i < req_cyc.size(); i++) check("t1_req_cyc", req_cyc[i], 1 + i);
    check("t1_first_val", first_val, 4);
    check("t1_last_val", last_val, 7);
    check("t1_nval", nval, 4);
    if (hs_cyc.size() == 4) check("t1_last_cyc", hs_cyc[3], 7);
    check("t1_done_cyc", done_cyc, 8);
    check("t1_busy_at_done", busy_at_done, 0);
    check("t1_busy_seen", busy_max, 1);

    // Wrap across the non-power-of-two end of the buffer.
    run_cmd(RAM_SIZE - 2, 4, 100, -1, 40);
    check_stream("t2", RAM_SIZE - 2, 4);
    check("t2_done_cyc", done_cyc, 8);

    // Zero length: done next cycle, nothing else moves.
    run_cmd(7, 0, 100, -1, 10);
    check("t3_nreq", req_cyc.size(), 0);
    check("t3_nval", nval, 0);
    check("t3_done_cyc", done_cyc, 1);
    check("t3_busy", busy_max, 0);

    // Random backpressure.
    run_cmd(40, 20, 30, -1, 600);
    check_stream("t4", 40, 20);
    check("t4_occ_ok", occ_max <= DEPTH, 1);
    check("t4_stall_stable", stall_err, 0);
    check("t4_done_seen", done_cyc >= 0, 1);

    // Start while busy is ignored.
    run_cmd(5, 3, 100, 2, 40);
    check_stream("t5", 5, 3);
    check("t5_done_cyc", done_cyc, 7);
    repeat (3) @(negedge clk);
    check("t5_idle_after", busy, 0);
    check("t5_no_valid_after", bus.out_valid, 0);

    // Reset during byte 5 of 16, then a fresh command amid stale returns.
    @(negedge clk);
    start = 1'b1; start_addr = AW'(20); length = (AW + 1)'(16); bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; guard = 0;
    while (!(cnt == 4 && bus.out_valid) && guard < 50) begin
      if (bus.out_valid && bus.out_ready) cnt++;
      @(negedge clk);
      guard++;
    end
    check("t6_reached_byte5", cnt, 4);
    reset = 1'b0;
    @(negedge clk);
    check_outputs_zero("t6_rst");
    reset = 1'b1;
    run_cmd(0, 3, 100, -1, 40);
    check_stream("t6", 0, 3);
    check("t6_nval", nval, 3);
    check("t6_done_cyc", done_cyc, 7);

`ifdef PACKET_STREAMER_ABORT_EN
    // Abort at byte 3 of 10.
    @(negedge clk);
    start = 1'b1; start_addr = AW'(15); length = (AW + 1)'(10); bus.out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0; guard = 0; done_any = 0;
    while (!(cnt == 2 && bus.out_valid) && guard < 50) begin
      if (bus.out_valid && bus.out_ready) cnt++;
      @(negedge clk);
      guard++;
    end
    check("t7_reached_byte3", cnt, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t7_valid_low", bus.out_valid, 0);
    guard = 0;
    while (busy && guard < 20) begin
      if (done) done_any = 1;
      if (bus.out_valid) done_any = 2;
      @(negedge clk);
      guard++;
    end
    if (done) done_any = 1;
    check("t7_no_done_no_valid", done_any, 0);
    check("t7_busy_cleared", busy, 0);
    run_cmd(2, 2, 100, -1, 30);
    check_stream("t7_after", 2, 2);
`else
    done_any = 0;
    check("t8_idle_end", busy + done_any, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
